// File: rtl/clint_if.sv
// Bus bundle between the core and the CLINT sequencer: interrupt lines, EX-stage
// trap events, current CSR image, the dedicated CSR write port and the fetch redirect.
interface clint_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_en_i;
  logic               ex_valid_i;
  logic [31:0]        ex_pc_i;
  logic               ecall_i;
  logic               ebreak_i;
  logic               mret_i;
  logic [31:0]        csr_mtvec_i;
  logic [31:0]        csr_mepc_i;
  logic [31:0]        csr_mstatus_i;
  logic               csr_we_o;
  logic [11:0]        csr_waddr_o;
  logic [31:0]        csr_wdata_o;
  logic               hold_flag_o;
  logic               br_taken_o;
  logic [31:0]        br_target_o;
  logic [NUM_IRQ-1:0] irq_ack_o;

  modport slave (
    input  irq_i, irq_en_i, ex_valid_i, ex_pc_i, ecall_i, ebreak_i, mret_i,
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o, br_taken_o,
    output br_target_o, irq_ack_o
  );

  modport master (
    output irq_i, irq_en_i, ex_valid_i, ex_pc_i, ecall_i, ebreak_i, mret_i,
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o, br_taken_o,
    input  br_target_o, irq_ack_o
  );
endinterface

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: accepts one trap event while idle and
// replays a fixed mepc/mcause/mstatus write sequence (or MRET restore) then redirects fetch.
module clint #(
  parameter int NUM_IRQ     = 4,
  parameter int MCAUSE_BASE = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  clint_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    R_MSTATUS,
    JUMP
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irq_pick;
  logic               take_mret;
  logic               take_ecall;
  logic               take_ebreak;
  logic               take_irq;
  logic               accept;
  logic [31:0]        cause_new;

  logic [31:0]        cause_q;
  logic [31:0]        mstatus_q;
  logic [31:0]        mtvec_q;
  logic [31:0]        mepc_q;

  logic               csr_we;
  logic [11:0]        csr_waddr;
  logic [31:0]        csr_wdata;
  logic               br_taken;
  logic [31:0]        br_target;
  logic [NUM_IRQ-1:0] irq_ack;

  function automatic logic [NUM_IRQ-1:0] lowest_onehot(input logic [NUM_IRQ-1:0] v);
    logic [NUM_IRQ-1:0] r;
    r = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] irq_cause(input logic [NUM_IRQ-1:0] onehot);
    logic [31:0] c;
    c = 32'h0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (onehot[i]) c = {1'b1, 31'(MCAUSE_BASE + i)};
    end
    return c;
  endfunction

  // Trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [31:0] entry_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1.
  function automatic logic [31:0] return_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  always_comb begin
    pending     = bus.irq_i & bus.irq_en_i & {NUM_IRQ{bus.csr_mstatus_i[3]}};
    irq_pick    = lowest_onehot(pending);
    take_mret   = bus.ex_valid_i & bus.mret_i;
    take_ecall  = bus.ex_valid_i & bus.ecall_i & ~bus.mret_i;
    take_ebreak = bus.ex_valid_i & bus.ebreak_i & ~bus.mret_i & ~bus.ecall_i;
    take_irq    = bus.ex_valid_i & (|pending) & ~bus.mret_i & ~bus.ecall_i & ~bus.ebreak_i;
    accept      = (state == IDLE) & (take_mret | take_ecall | take_ebreak | take_irq);
    cause_new   = take_ecall  ? 32'd11 :
                  take_ebreak ? 32'd3  : irq_cause(irq_pick);
  end

  // Hold is the only combinational output so the controller stalls in the accept cycle.
  assign bus.hold_flag_o = rst_n & (accept | (state != IDLE));

  // Snapshot stage: the sequence runs from these, never from the live inputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      cause_q   <= cause_new;
      mstatus_q <= bus.csr_mstatus_i;
      mtvec_q   <= bus.csr_mtvec_i;
      mepc_q    <= bus.csr_mepc_i;
    end
  end

  // Sequencer stage: each state's outputs are registered on entry to that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      csr_we    <= 1'b0;
      csr_waddr <= 12'h0;
      csr_wdata <= 32'h0;
      br_taken  <= 1'b0;
      br_target <= 32'h0;
      irq_ack   <= '0;
    end else begin
      csr_we    <= 1'b0;
      csr_waddr <= 12'h0;
      csr_wdata <= 32'h0;
      br_taken  <= 1'b0;
      br_target <= 32'h0;
      irq_ack   <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            csr_we <= 1'b1;
            if (take_mret) begin
              state     <= R_MSTATUS;
              csr_waddr <= 12'h300;
              csr_wdata <= return_mstatus(bus.csr_mstatus_i);
            end else begin
              state     <= W_MEPC;
              csr_waddr <= 12'h341;
              csr_wdata <= bus.ex_pc_i;
              if (take_irq) irq_ack <= irq_pick;
            end
          end
        end
        W_MEPC: begin
          state     <= W_MCAUSE;
          csr_we    <= 1'b1;
          csr_waddr <= 12'h342;
          csr_wdata <= cause_q;
        end
        W_MCAUSE: begin
          state     <= W_MSTATUS;
          csr_we    <= 1'b1;
          csr_waddr <= 12'h300;
          csr_wdata <= entry_mstatus(mstatus_q);
        end
        W_MSTATUS: begin
          state     <= JUMP;
          br_taken  <= 1'b1;
          br_target <= mtvec_q & ~32'h3;
        end
        R_MSTATUS: begin
          state     <= JUMP;
          br_taken  <= 1'b1;
          br_target <= mepc_q;
        end
        JUMP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.csr_we_o    = csr_we;
  assign bus.csr_waddr_o = csr_waddr;
  assign bus.csr_wdata_o = csr_wdata;
  assign bus.br_taken_o  = br_taken;
  assign bus.br_target_o = br_target;
  assign bus.irq_ack_o   = irq_ack;

endmodule

// File: doc/clint.md
# clint

Core-local interrupt/exception sequencer for the pipelined RV32I core with exception and interrupt support. It takes NUM_IRQ level-sensitive interrupt lines and the synchronous ECALL/EBREAK/MRET events from the EX stage. For each one it runs a fixed multi-cycle trap-entry or trap-return sequence: it writes mepc/mcause/mstatus through a dedicated CSR write port, then redirects fetch. While the sequence runs, it drives `hold_flag_o` into the controller's `hold_flag_clint_i` to stall the pipeline.

## Interface
Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16)
- MCAUSE_BASE, 16, mcause exception code for irq line 0; line i reports MCAUSE_BASE+i

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_i  in  NUM_IRQ  level-sensitive interrupt requests
- irq_en_i  in  NUM_IRQ  per-line enable (mie image)
- ex_valid_i  in  1  EX stage holds a valid instruction
- ex_pc_i  in  32  PC of the instruction in EX
- ecall_i / ebreak_i / mret_i  in  1 each  EX instruction is ECALL / EBREAK / MRET (qualified by ex_valid_i)
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  current CSR values
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data
- hold_flag_o  out  1  pipeline hold to controller
- br_taken_o  out  1  one-cycle fetch redirect
- br_target_o  out  32  redirect target
- irq_ack_o  out  NUM_IRQ  one-hot acknowledge pulse of the accepted line

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, JUMP.
- Event selection happens only in IDLE with ex_valid_i=1. Priority order: mret_i > ecall_i > ebreak_i > interrupt.
- Interrupt pending vector = irq_i & irq_en_i & {NUM_IRQ{csr_mstatus_i[3]}}. Among pending lines, the lowest index wins.
- ECALL/EBREAK are taken regardless of MIE.
- On acceptance, the block snapshots the following into registers, and the sequence then runs from those snapshots:
  - ex_pc_i → mepc value. The EX instruction is squashed and is re-executed after MRET. For ECALL/EBREAK, mepc is the trapping instruction itself.
  - cause: ECALL = 32'd11; EBREAK = 32'd3; interrupt line i = {1'b1, 31'(MCAUSE_BASE+i)}.
  - csr_mstatus_i, csr_mtvec_i, csr_mepc_i.
- Trap entry: IDLE → W_MEPC (write 0x341 = saved pc) → W_MCAUSE (write 0x342 = cause) → W_MSTATUS (write 0x300 = saved mstatus with bit7 MPIE ← bit3 MIE and bit3 MIE ← 0) → JUMP (br_taken_o=1, br_target_o = saved mtvec & ~32'h3) → IDLE.
- Trap return (MRET): IDLE → R_MSTATUS (write 0x300 = saved mstatus with MIE ← MPIE and MPIE ← 1) → JUMP (target = saved mepc) → IDLE.
- csr_we_o is high only in the W_* and R_MSTATUS states. csr_waddr_o and csr_wdata_o are 0 whenever csr_we_o=0.
- Outside IDLE, all new events are ignored. Deassertion of irq_i mid-sequence does not abort the sequence.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset asserted mid-sequence aborts immediately, and no partial writes occur after reset.
- Accept cycle T is combinational: hold_flag_o = (state != IDLE) | accept. Hold is therefore high from T through JUMP inclusive.
- Trap entry:
  - mepc write at T+1, mcause write at T+2, mstatus write at T+3.
  - br_taken_o at T+4.
  - Back in IDLE at T+5; a new event can be accepted at T+5 at the earliest.
- MRET: mstatus write at T+1, br_taken_o at T+2, back in IDLE at T+3.
- irq_ack_o is a single-cycle one-hot pulse at T+1, for interrupts only.
- All outputs except hold_flag_o are registered-state decodes with no combinational path from the inputs.

## Test plan
- Reset then idle: all outputs are 0 and irq_i=0 produces no activity.
- irq_i=4'b0110, irq_en_i=4'hF, MIE=1, ex_pc_i=0x40, mtvec=0x101, mstatus=0x8 → writes at T+1..T+3 are 0x341←0x40, 0x342←0x80000011, 0x300←0x80. br_taken_o=1 with target 0x100 at T+4. irq_ack_o=4'b0010 at T+1. hold_flag_o is high T..T+4.
- MIE=0 with an irq pending → no activity. Then ecall_i with ex_pc_i=0x20 → 0x342←11 and redirect to mtvec.
- mret_i and irq_i asserted in the same cycle, with mstatus=0x80 and mepc=0x44 → 0x300←0x88 at T+1 and redirect to 0x44 at T+2. The interrupt is accepted no earlier than T+3.
- irq_i drops at T+2 → the sequence still completes through JUMP.
- rst_n asserted at T+2 → outputs are 0 immediately, and after release the block is in IDLE with no pending write.
